find_one_rr_arbiter: RTL and testbench
======================================

Name: find_one_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among NUM_REQUESTER requesters; owns the grant, hold and release sequencing.
- Priority selection is descending-index, highest-index-first priority encoding, with a rotating mask applied after each grant.
- Grants are held until the owner releases the resource, drops its request, or exceeds a programmable hold limit.
- Sits in front of shared resources such as a memory port, bus or refill engine.

Parameters:
- NUM_REQUESTER, 8, number of requesters (>= 2).
- INDEX_WIDTH, 3, width of the grant index; must be >= clog2(NUM_REQUESTER).
- MAX_HOLD_CYCLES, 16, maximum consecutive cycles one grant is held; 0 disables the timeout.

Ports:
- clk_in  input  1  clock, all logic on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- request_in  input  NUM_REQUESTER  per-requester request level; held high while the requester wants the resource.
- release_in  input  1  current owner done; honoured only while grant_valid_out=1.
- grant_out  output  NUM_REQUESTER  one-hot grant, registered.
- grant_index_out  output  INDEX_WIDTH  binary index of the owner; 0 when idle.
- grant_valid_out  output  1  a grant is active.
- timeout_out  output  1  one-cycle pulse, high during the final cycle of a grant ended by hold timeout.

Behaviour:
- Reset (reset_in=1 at an edge):
  - grant_out=0, grant_index_out=0, grant_valid_out=0, timeout_out=0.
  - Priority pointer P=0, hold counter=0, state IDLE.
  - Reset mid-grant drops the grant at that edge; no timeout pulse is produced.
- State IDLE:
  - If request_in != 0, compute the winner, register it, go to GRANT.
  - grant_out is high in the cycle after the request is sampled (latency 1).
  - If request_in == 0, stay in IDLE; outputs stay 0.
- Winner selection:
  - masked = request_in & ((1<<P)-1).
  - If masked != 0, the winner is the highest set index of masked; otherwise it is the highest set index of request_in.
  - This gives the order P-1 down to 0, then NUM_REQUESTER-1 down to P.
  - On each new grant, P := winner index.
- State GRANT:
  - grant_out, grant_index_out and grant_valid_out are held constant.
  - The hold counter counts the cycles grant_valid_out has been high; the first grant cycle = 1.
- End of grant, evaluated each GRANT cycle:
  - (a) release_in=1, or (b) request_in[owner]=0: normal end.
  - (c) MAX_HOLD_CYCLES!=0 and counter==MAX_HOLD_CYCLES: timeout end; timeout_out=1 in that same cycle.
  - If (a) or (b) coincides with (c), it is a normal end and timeout_out stays 0.
- On any end:
  - Arbitrate immediately on request_in sampled in the ending cycle, using the updated P.
  - If there is a winner, the next cycle shows the new grant with no idle bubble, and the counter restarts at 1.
  - If there is no winner, go to IDLE with outputs cleared.
  - The just-released owner may be regranted only if it is the sole requester.
- Invariants:
  - grant_out is always one-hot or zero.
  - grant_valid_out == |grant_out.
  - grant_out[grant_index_out]=1 whenever valid.
- release_in while IDLE is ignored.
- Changes to non-owner request bits during GRANT do not affect the grant.
- The hold counter saturates logic is not needed beyond MAX_HOLD_CYCLES; width is clog2(MAX_HOLD_CYCLES+1).

Test Plan:
- Basic priority and rotation (N=8):
  - After reset, request_in=8'b0010_0100 held → next cycle grant_out=8'h20, index 5.
  - Pulse release_in → next cycle grant index 2.
  - Pulse release_in again with both still requesting → grant index 5.
- Empty and idle:
  - request_in=0 for 10 cycles → all outputs 0.
  - release_in pulses while idle → no change.
- Timeout (MAX_HOLD_CYCLES=4):
  - request_in=8'h01 held, no release → grant_valid_out high exactly 4 cycles.
  - timeout_out=1 only in the 4th cycle.
  - Next cycle regrant of index 0, with the counter restarted.
- Request drop:
  - Index 6 granted, then request_in[6] falls while request_in[1]=1 → next cycle grant index 1, timeout_out=0.
- Simultaneous events (MAX_HOLD_CYCLES=4):
  - release_in=1 in the 4th grant cycle → timeout_out stays 0; normal handover.
- Reset mid-grant:
  - reset_in during an index-3 grant → next cycle all outputs 0, P=0.
  - With request_in=8'h88 then applied → grant index 7.

Source files
------------

// File: rtl/find_one_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : find_one_rr_arbiter
// Description : Round-robin arbiter (highest-index-first, rotating mask) that
//               holds each grant until release, request drop or hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module find_one_rr_arbiter #(
    parameter int NUM_REQUESTER   = 8,
    parameter int INDEX_WIDTH     = 3,
    parameter int MAX_HOLD_CYCLES = 16
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [NUM_REQUESTER-1:0] request_in,
    input  logic                     release_in,
    output logic [NUM_REQUESTER-1:0] grant_out,
    output logic [INDEX_WIDTH-1:0]   grant_index_out,
    output logic                     grant_valid_out,
    output logic                     timeout_out
);

    localparam int C_CNT_WIDTH = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
    localparam logic [C_CNT_WIDTH-1:0] C_HOLD_MAX = C_CNT_WIDTH'(MAX_HOLD_CYCLES);
    localparam logic [C_CNT_WIDTH-1:0] C_CNT_ONE  = C_CNT_WIDTH'(1);
    localparam bit C_TIMEOUT_EN = (MAX_HOLD_CYCLES != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_REQUESTER-1:0] grant_q, grant_d;
    logic [INDEX_WIDTH-1:0]   index_q, index_d;
    logic [INDEX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [C_CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [NUM_REQUESTER-1:0] w_mask;
    logic [NUM_REQUESTER-1:0] w_masked;
    logic [NUM_REQUESTER-1:0] w_cand;
    logic [NUM_REQUESTER-1:0] w_win_onehot;
    logic [INDEX_WIDTH-1:0]   w_win_idx;
    logic                     w_win_vld;
    logic                     w_owner_req;
    logic                     w_normal_end;
    logic                     w_hold_end;
    logic                     w_timeout;
    logic                     w_load;

    // Requesters strictly below the pointer win first; otherwise fall back
    // to the full request vector. The last set bit in the scan is the highest.
    always_comb begin
        w_mask       = '0;
        w_win_idx    = '0;
        w_win_onehot = '0;
        for (int i = 0; i < NUM_REQUESTER; i++) begin
            w_mask[i] = (INDEX_WIDTH'(i) < ptr_q);
        end
        w_masked  = request_in & w_mask;
        w_cand    = (|w_masked) ? w_masked : request_in;
        w_win_vld = |request_in;
        for (int i = 0; i < NUM_REQUESTER; i++) begin
            if (w_cand[i]) begin
                w_win_idx = INDEX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQUESTER; i++) begin
            w_win_onehot[i] = w_win_vld && (w_win_idx == INDEX_WIDTH'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        index_d      = index_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        w_timeout    = 1'b0;
        w_load       = 1'b0;
        w_owner_req  = |(request_in & grant_q);
        w_normal_end = release_in || !w_owner_req;
        w_hold_end   = C_TIMEOUT_EN && (cnt_q == C_HOLD_MAX);

        case (state_q)
            ST_IDLE: begin
                w_load = w_win_vld;
            end
            ST_GRANT: begin
                if (w_normal_end || w_hold_end) begin
                    // A normal end takes precedence over a coincident timeout.
                    w_timeout = w_hold_end && !w_normal_end;
                    w_load    = w_win_vld;
                    if (!w_win_vld) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        index_d = '0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != C_HOLD_MAX) begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                index_d = '0;
                cnt_d   = '0;
            end
        endcase

        if (w_load) begin
            state_d = ST_GRANT;
            grant_d = w_win_onehot;
            index_d = w_win_idx;
            ptr_d   = w_win_idx;
            cnt_d   = C_CNT_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            index_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_out       = grant_q;
    assign grant_index_out = index_q;
    assign grant_valid_out = (state_q == ST_GRANT);
    assign timeout_out     = w_timeout && !reset_in;

endmodule
`default_nettype wire

// File: tb/tb_find_one_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_find_one_rr_arbiter
// Description : Directed vector bench for find_one_rr_arbiter (N=8, hold=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_find_one_rr_arbiter;

    localparam int C_N   = 8;
    localparam int C_IW  = 3;
    localparam int C_MAX = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [C_N-1:0]  req = '0;
    logic            rel = 1'b0;
    logic [C_N-1:0]  grant;
    logic [C_IW-1:0] gidx;
    logic            gvld;
    logic            gto;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req;
        logic       rel;
        logic [7:0] grant;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    find_one_rr_arbiter #(
        .NUM_REQUESTER  (C_N),
        .INDEX_WIDTH    (C_IW),
        .MAX_HOLD_CYCLES(C_MAX)
    ) u_dut (
        .clk_in         (clk),
        .reset_in       (rst),
        .request_in     (req),
        .release_in     (rel),
        .grant_out      (grant),
        .grant_index_out(gidx),
        .grant_valid_out(gvld),
        .timeout_out    (gto)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                              input logic ev, input logic et);
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".index"}, 32'(gidx), 32'(ei));
        check({tag, ".valid"}, 32'(gvld), 32'(ev));
        check({tag, ".timeout"}, 32'(gto), 32'(et));
        check({tag, ".onehot"}, 32'($onehot0(grant)), 32'd1);
    endtask

    // Drive inputs, settle, compare, then advance one clock.
    task automatic step(input string tag, input logic [7:0] r, input logic l,
                        input logic [7:0] eg, input logic [2:0] ei, input logic ev, input logic et);
        req = r;
        rel = l;
        #1;
        check_outs(tag, eg, ei, ev, et);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Rotation: 5 -> 2 -> 5, then owner drop to idle
        vecs.push_back('{8'h24, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h24, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0});
        vecs.push_back('{8'h24, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0});
        vecs.push_back('{8'h24, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0});
        vecs.push_back('{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0});
        // Idle, releases ignored
        vecs.push_back('{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) vecs.push_back('{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
        // Timeout on sole requester 0, regrant without bubble
        vecs.push_back('{8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1});
        // Restarted counter: release in 4th cycle is a normal end
        vecs.push_back('{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0});
        // Request drop: owner 6 falls, 1 takes over
        vecs.push_back('{8'h40, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h42, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0});
        vecs.push_back('{8'h02, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0});
        vecs.push_back('{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0});
        // Timeout with a competitor: 6 and 1, owner 6 times out -> 1
        vecs.push_back('{8'h40, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h42, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0});
        vecs.push_back('{8'h42, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0});
        vecs.push_back('{8'h42, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0});
        vecs.push_back('{8'h42, 1'b0, 8'h40, 3'd6, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0});

        // Reset
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_outs("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].rel,
                 vecs[i].grant, vecs[i].idx, vecs[i].vld, vecs[i].to);
        end

        // Reset mid-grant of index 3 (pointer was 1 -> 3 wins from 0x08)
        step("mr.idle", 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step("mr.g3a", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        rst = 1'b1;
        step("mr.g3b", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        rst = 1'b0;
        // Pointer must be 0 again: 0x0A yields 3, a stale pointer of 3 would yield 1
        step("mr.post", 8'h0A, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step("mr.ptr0", 8'h88, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0);
        step("mr.g7", 8'h00, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        step("mr.end", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
